// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared types for the stopwatch button sequencer
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    SW_IDLE,
    SW_RUN,
    SW_LAP,
    SW_STOP
  } sw_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - level debouncer emitting a one-cycle press on each accepted rise
module button_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             stable;
  logic [CNT_W-1:0] cnt;

  // The toggle fires on the Nth consecutive differing sample; press is registered with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= raw;
        cnt    <= '0;
        press  <= raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - start/stop and lap/clear sequencer with lap snapshot display mux
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] live_d0,
  input  logic [3:0] live_d1,
  input  logic [3:0] live_d2,
  input  logic [3:0] live_d3,
  output logic       run,
  output logic       clear,
  output logic       lap_active,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3
);

  logic      ss_p;
  logic      lr_p;
  sw_state_t state;
  sw_state_t state_nxt;
  logic      clear_nxt;
  logic      capture;
  bcd_t      lap_d0;
  bcd_t      lap_d1;
  bcd_t      lap_d2;
  bcd_t      lap_d3;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_ss (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_ss),
    .press(ss_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_lr (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_lr),
    .press(lr_p)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SW_IDLE;
      clear  <= 1'b0;
      lap_d0 <= '0;
      lap_d1 <= '0;
      lap_d2 <= '0;
      lap_d3 <= '0;
    end else begin
      state <= state_nxt;
      clear <= clear_nxt;
      if (capture) begin
        lap_d0 <= live_d0;
        lap_d1 <= live_d1;
        lap_d2 <= live_d2;
        lap_d3 <= live_d3;
      end
    end
  end

  // Start/stop has priority: a simultaneous lap/clear press is dropped.
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    capture   = 1'b0;
    case (state)
      SW_IDLE: begin
        if (ss_p)      state_nxt = SW_RUN;
        else if (lr_p) clear_nxt = 1'b1;
      end
      SW_RUN: begin
        if (ss_p) begin
          state_nxt = SW_STOP;
        end else if (lr_p) begin
          state_nxt = SW_LAP;
          capture   = 1'b1;
        end
      end
      SW_LAP: begin
        if (ss_p)      state_nxt = SW_STOP;
        else if (lr_p) state_nxt = SW_RUN;
      end
      SW_STOP: begin
        if (ss_p) begin
          state_nxt = SW_RUN;
        end else if (lr_p) begin
          state_nxt = SW_IDLE;
          clear_nxt = 1'b1;
        end
      end
      default: state_nxt = SW_IDLE;
    endcase
  end

  assign run        = (state == SW_RUN) || (state == SW_LAP);
  assign lap_active = (state == SW_LAP);

  assign disp_d0 = lap_active ? lap_d0 : live_d0;
  assign disp_d1 = lap_active ? lap_d1 : live_d1;
  assign disp_d2 = lap_active ? lap_d2 : live_d2;
  assign disp_d3 = lap_active ? lap_d3 : live_d3;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Button-driven sequencer for the 4-digit stopwatch datapath: start/stop, lap/clear.
- Debounces two raw push-button levels and turns presses into one-cycle events.
- Runs a 4-state FSM that drives the stopwatch `run` enable and a one-cycle `clear` pulse.
- Holds a lap snapshot of the four BCD digits and muxes live or lap digits to the display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a raw button level must be stable before it is accepted (10 ms at 100 MHz). Legal range: >=2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; do not override.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_ss  input  1  raw start/stop button level, already synchronized to clk
- btn_lr  input  1  raw lap/clear button level, already synchronized to clk
- live_d0..live_d3  input  4 each  live BCD digits from the stopwatch (d0 = 0.01 s, d3 = 10 s)
- run  output  1  count enable to the stopwatch
- clear  output  1  one-cycle pulse to the stopwatch reset input
- lap_active  output  1  high while the display is frozen on the lap snapshot
- disp_d0..disp_d3  output  4 each  digits to the display driver

Behaviour:
- Clock and reset are fixed: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values: state = SW_IDLE, run = 0, clear = 0, lap_active = 0, lap registers = 0, debouncer stable levels = 0, debouncer counters = 0.
- Debouncer, one per button:
  - Counter increments while the raw input differs from the stable level; it clears whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level toggles and the counter clears.
  - On a 0->1 toggle of the stable level, the press output (ss_p or lr_p) is high for exactly one cycle, in the cycle after the toggle edge.
  - Latency: raw rises before edge k and stays high; the stable level flips at edge k+N-1; the press is visible in cycle k+N (N = DEBOUNCE_CYCLES).
  - Bounces shorter than N cycles produce no press. Releases produce no press.
- FSM: Moore outputs registered, updated on the edge that consumes the press. If ss_p and lr_p are high in the same cycle, ss_p wins and lr_p is dropped.
  - SW_IDLE: ss_p -> SW_RUN. lr_p -> stay in SW_IDLE, pulse clear.
  - SW_RUN: ss_p -> SW_STOP. lr_p -> SW_LAP; capture live_d0..d3 into the lap registers on the same edge.
  - SW_LAP: ss_p -> SW_STOP; the display reverts to live digits. lr_p -> SW_RUN; the snapshot is released.
  - SW_STOP: ss_p -> SW_RUN. lr_p -> SW_IDLE, pulse clear.
- Output decode:
  - run = 1 in SW_RUN and SW_LAP, 0 otherwise.
  - lap_active = 1 only in SW_LAP.
  - clear = 1 for exactly the cycle after the edge that took the clearing transition. Back-to-back clears need two separate debounced presses.
- Display mux (combinational): disp_dN = lap_dN when lap_active, else live_dN. Lap registers keep their value after leaving SW_LAP; only a new capture or `reset` changes them.
- Reset mid-operation: `reset` overrides every transition. Any press pending in the reset cycle is lost. The FSM is in SW_IDLE on the cycle after reset deasserts.
- The block does not interpret digit values. Rollover at 59.99 s is the stopwatch's behaviour; during SW_LAP the display stays frozen across rollover.

Decomposition:
- Package stopwatch_ctrl_pkg:
  - typedef enum logic [1:0] sw_state_t {SW_IDLE, SW_RUN, SW_LAP, SW_STOP}
  - typedef logic [3:0] bcd_t
- Sub-module button_debounce (params DEBOUNCE_CYCLES, CNT_W; ports clk, reset, raw, press), instantiated twice.
- FSM, lap registers and display mux live in stopwatch_ctrl.

Test Plan (DEBOUNCE_CYCLES = 4 unless noted):
- Reset, then btn_ss high for 10 cycles -> exactly one ss_p; run rises 5 cycles after btn_ss rose; clear stays 0.
- btn_ss toggles with a high/low pattern of 1,2,1,3 cycles, then settles low -> no press; run stays 0 and state stays SW_IDLE.
- In SW_RUN with live digits 3,2,1,0 (d0..d3) at the capture edge, press btn_lr -> lap_active = 1; disp = 3,2,1,0 while live changes; a second btn_lr press -> lap_active = 0 and disp tracks live.
- In SW_RUN press btn_ss (-> SW_STOP), then btn_lr -> run = 0; clear high for exactly 1 cycle; state = SW_IDLE; second btn_lr -> another single clear pulse.
- In SW_RUN, btn_ss and btn_lr rise on the same cycle and stay high -> state = SW_STOP; no lap capture; lap_active = 0.
- In SW_LAP, assert reset for 1 cycle -> run = 0, lap_active = 0, disp = live digits, lap registers = 0, state = SW_IDLE.
